// File: rtl/ct_ifu_predecd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ct_ifu_predecd_pkg
//  Description : Shared FSM encoding and parity helper for the multi-bank
//                ICache predecode array.
//  Revision    : 1.0 - initial multi-bank release
// ============================================================================
package ct_ifu_predecd_pkg;

    // Sweep controller state encoding
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_INV  = 2'b01;
    localparam logic [1:0] c_ST_DONE = 2'b10;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended by the caller, which leaves the XOR unchanged.
    localparam int c_PAR_MAX_W = 1024;

    // Even-parity bit: makes the total number of ones (data + bit) even.
    function automatic logic f_even_par(input logic [c_PAR_MAX_W-1:0] i_data);
        return ^i_data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_ifu_predecd_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ct_ifu_predecd_bank
//  Description : Single-port synchronous RAM, one-cycle read latency. The
//                read register only updates on a read, so it holds the last
//                read value across writes and idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_ifu_predecd_bank #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_cen_b,
    input  logic              i_wen_b,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_din,
    output logic [WIDTH-1:0]  o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // Array write port
    always_ff @(posedge clk) begin
        if (!i_cen_b && !i_wen_b) begin
            r_mem[i_addr] <= i_din;
        end
    end

    // Read register, cleared by reset, loaded only on a read
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_q <= '0;
        end else if (!i_cen_b && i_wen_b) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_dout = r_q;

endmodule
`default_nettype wire

// File: rtl/gated_clk_cell.sv
`default_nettype none
// ============================================================================
//  Module      : gated_clk_cell
//  Description : Latch-based glitch-free clock gate. The enable is captured
//                while the clock is low so the gated clock never chops a
//                high phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic w_clk_en;
    logic r_clk_en_lat;

    assign w_clk_en = (global_en & (module_en | local_en)) | external_en;

    // Transparent-low enable latch
    always_latch begin
        if (!clk_in) begin
            r_clk_en_lat <= w_clk_en;
        end
    end

    assign clk_out = clk_in & (r_clk_en_lat | pad_yy_icg_scan_en);

endmodule
`default_nettype wire

// File: rtl/ct_ifu_icache_predecd_array_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ct_ifu_icache_predecd_array_gen
//  Description : Multi-bank ICache predecode array with per-entry parity,
//                hardware invalidation sweep and registered read-valid.
//  Revision    : 1.0 - initial multi-bank release
// ============================================================================
module ct_ifu_icache_predecd_array_gen
    import ct_ifu_predecd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int BANKS     = 2,
    parameter int PARITY_EN = 1,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    cp0_yy_clk_en,
    input  logic                    cp0_ifu_icg_en,
    input  logic                    pad_yy_icg_scan_en,
    input  logic [BANKS-1:0]        ifu_predecd_cen_b,
    input  logic                    ifu_predecd_wen_b,
    input  logic [ADDR_W-1:0]       ifu_predecd_index,
    input  logic [BANKS*DATA_W-1:0] ifu_predecd_din,
    input  logic                    ifu_predecd_inv_req,
    output logic [BANKS*DATA_W-1:0] predecd_ifu_dout,
    output logic [BANKS-1:0]        predecd_ifu_dout_vld,
    output logic [BANKS-1:0]        predecd_ifu_par_err,
    output logic                    predecd_ifu_inv_busy,
    output logic                    predecd_ifu_inv_done
);

    localparam int              c_RAM_W    = DATA_W + PARITY_EN;
    localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]       r_state;
    logic [ADDR_W:0]  r_inv_cnt;
    logic [BANKS-1:0] r_dout_vld;
    logic             w_busy;
    logic             w_start;
    logic             w_ext_ok;
    logic             w_local_en;
    logic             w_clk;

    assign w_busy   = (r_state == c_ST_INV);
    assign w_start  = (r_state == c_ST_IDLE) & ifu_predecd_inv_req;
    // External accesses are dropped during a sweep and in the request cycle
    assign w_ext_ok = (r_state != c_ST_INV) & ~w_start;

    // Clock must also run while the FSM is outside IDLE (DONE has to retire),
    // while a valid pulse needs clearing, and while reset is applied.
    assign w_local_en = (r_state != c_ST_IDLE) | (|r_dout_vld)
                      | ~&ifu_predecd_cen_b | ifu_predecd_inv_req | ~cpurst_b;

    gated_clk_cell u_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (w_local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (w_clk)
    );

    // Sweep controller: reset lands in INV so every reset is followed by a sweep
    always_ff @(posedge w_clk) begin
        if (!cpurst_b) begin
            r_state   <= c_ST_INV;
            r_inv_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ifu_predecd_inv_req) begin
                        r_state   <= c_ST_INV;
                        r_inv_cnt <= '0;
                    end
                end
                c_ST_INV: begin
                    if (r_inv_cnt == c_LAST_IDX) begin
                        r_state   <= c_ST_DONE;
                        r_inv_cnt <= '0;
                    end else begin
                        r_inv_cnt <= r_inv_cnt + 1'b1;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Read-valid, one cycle after an accepted read of each bank
    always_ff @(posedge w_clk) begin
        if (!cpurst_b) begin
            r_dout_vld <= '0;
        end else if (w_ext_ok && ifu_predecd_wen_b) begin
            r_dout_vld <= ~ifu_predecd_cen_b;
        end else begin
            r_dout_vld <= '0;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0]  w_din_b;
        logic [c_RAM_W-1:0] w_wdata;
        logic [c_RAM_W-1:0] w_q;
        logic               w_cen_b;

        assign w_din_b = ifu_predecd_din[b*DATA_W +: DATA_W];
        assign w_cen_b = w_busy ? 1'b0 : (w_ext_ok ? ifu_predecd_cen_b[b] : 1'b1);

        if (PARITY_EN != 0) begin : g_par
            assign w_wdata = w_busy ? '0
                           : {f_even_par(c_PAR_MAX_W'(w_din_b)), w_din_b};
            assign predecd_ifu_par_err[b] = r_dout_vld[b]
                & (f_even_par(c_PAR_MAX_W'(w_q[DATA_W-1:0])) ^ w_q[DATA_W]);
        end else begin : g_nopar
            assign w_wdata = w_busy ? '0 : w_din_b;
            assign predecd_ifu_par_err[b] = 1'b0;
        end

        ct_ifu_predecd_bank #(
            .WIDTH  (c_RAM_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (w_clk),
            .rst_b   (cpurst_b),
            .i_cen_b (w_cen_b),
            .i_wen_b (w_busy ? 1'b0 : ifu_predecd_wen_b),
            .i_addr  (w_busy ? r_inv_cnt[ADDR_W-1:0] : ifu_predecd_index),
            .i_din   (w_wdata),
            .o_dout  (w_q)
        );

        assign predecd_ifu_dout[b*DATA_W +: DATA_W] = w_q[DATA_W-1:0];
    end : g_bank

    assign predecd_ifu_dout_vld = r_dout_vld;
    assign predecd_ifu_inv_busy = w_busy;
    assign predecd_ifu_inv_done = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ct_ifu_icache_predecd_array_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_ifu_icache_predecd_array_gen
//  Description : Directed self-checking bench with a behavioural model of the
//                two-bank predecode array (parity and no-parity builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_ifu_icache_predecd_array_gen;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int NB    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en, icg_en, scan_en;
    logic [NB-1:0] cen_b;
    logic          wen_b;
    logic [9:0]    index;
    logic [63:0]   din;
    logic          inv_req;

    logic [63:0]   dout, dout_np;
    logic [NB-1:0] vld, vld_np, perr, perr_np;
    logic          busy, busy_np, done, done_np;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ct_ifu_icache_predecd_array_gen #(.DATA_W(DW), .DEPTH(DEPTH), .BANKS(NB), .PARITY_EN(1)) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .cp0_yy_clk_en(clk_en), .cp0_ifu_icg_en(icg_en),
        .pad_yy_icg_scan_en(scan_en), .ifu_predecd_cen_b(cen_b), .ifu_predecd_wen_b(wen_b),
        .ifu_predecd_index(index), .ifu_predecd_din(din), .ifu_predecd_inv_req(inv_req),
        .predecd_ifu_dout(dout), .predecd_ifu_dout_vld(vld), .predecd_ifu_par_err(perr),
        .predecd_ifu_inv_busy(busy), .predecd_ifu_inv_done(done));

    ct_ifu_icache_predecd_array_gen #(.DATA_W(DW), .DEPTH(DEPTH), .BANKS(NB), .PARITY_EN(0)) dut_np (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .cp0_yy_clk_en(clk_en), .cp0_ifu_icg_en(icg_en),
        .pad_yy_icg_scan_en(scan_en), .ifu_predecd_cen_b(cen_b), .ifu_predecd_wen_b(wen_b),
        .ifu_predecd_index(index), .ifu_predecd_din(din), .ifu_predecd_inv_req(inv_req),
        .predecd_ifu_dout(dout_np), .predecd_ifu_dout_vld(vld_np), .predecd_ifu_par_err(perr_np),
        .predecd_ifu_inv_busy(busy_np), .predecd_ifu_inv_done(done_np));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [NB][DEPTH];
    logic          m_par [NB][DEPTH];
    int            m_left = 0;
    bit            m_live = 0;
    logic          m_done;
    logic [NB-1:0] m_vld, m_perr;
    logic [63:0]   m_dout;

    task automatic model_step();
        bit was_done;
        if (!rst_n) begin
            m_live = 1; m_left = DEPTH; m_done = 0;
            m_vld = '0; m_perr = '0; m_dout = '0;
        end else if (m_left > 0) begin
            for (int b = 0; b < NB; b++) begin
                m_mem[b][DEPTH - m_left] = '0;
                m_par[b][DEPTH - m_left] = 1'b0;
            end
            m_left--;
            m_done = (m_left == 0);
            m_vld = '0; m_perr = '0;
        end else begin
            was_done = m_done;
            m_done = 0; m_vld = '0; m_perr = '0;
            if (inv_req && !was_done) begin
                m_left = DEPTH;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (!cen_b[b] && !wen_b) begin
                        m_mem[b][index] = din[b*DW +: DW];
                        m_par[b][index] = ^din[b*DW +: DW];
                    end else if (!cen_b[b]) begin
                        m_dout[b*DW +: DW] = m_mem[b][index];
                        m_vld[b]  = 1'b1;
                        m_perr[b] = (^m_mem[b][index]) ^ m_par[b][index];
                    end
                end
            end
        end
    endtask

    // Compare process: model advances on every edge, DUTs checked 1 unit later
    always begin
        @(posedge clk);
        model_step();
        #1;
        if (m_live) begin
            chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("vld", {62'd0, vld}, {62'd0, m_vld});
            chk("perr", {62'd0, perr}, {62'd0, m_perr});
            chk("dout", dout, m_dout);
            chk("np_busy", {63'd0, busy_np}, {63'd0, m_left > 0});
            chk("np_done", {63'd0, done_np}, {63'd0, m_done});
            chk("np_vld", {62'd0, vld_np}, {62'd0, m_vld});
            chk("np_perr", {62'd0, perr_np}, 64'd0);
            chk("np_dout", dout_np, m_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cen_b = '1; wen_b = 1'b1; inv_req = 1'b0;
        end
    endtask

    task automatic wr(input logic [1:0] bk, input logic [9:0] idx, input logic [63:0] d);
        @(negedge clk);
        cen_b = ~bk; wen_b = 1'b0; index = idx; din = d; inv_req = 1'b0;
    endtask

    task automatic rd(input logic [1:0] bk, input logic [9:0] idx);
        @(negedge clk);
        cen_b = ~bk; wen_b = 1'b1; index = idx; inv_req = 1'b0;
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Called just after the edge that started a sweep; measures its length
    task automatic wait_sweep(input string nm);
        int n_busy, n_done, n_vld;
        n_busy = busy ? 1 : 0; n_done = 0; n_vld = 0;
        for (int i = 0; i < DEPTH + 16; i++) begin
            @(posedge clk);
            #2;
            if (busy) n_busy++;
            if (done) n_done++;
            if (busy && vld != '0) n_vld++;
        end
        chk({nm, "_busy_len"}, 64'(n_busy), 64'(DEPTH));
        chk({nm, "_done_cnt"}, 64'(n_done), 64'd1);
        chk({nm, "_vld_busy"}, 64'(n_vld), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early_done;
        rst_n = 1'b0; clk_en = 1'b1; icg_en = 1'b0; scan_en = 1'b0;
        cen_b = '1; wen_b = 1'b1; index = '0; din = '0; inv_req = 1'b0;

        // Reset values and power-on sweep
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_vld", {62'd0, vld}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        rst_n = 1'b1;
        wait_sweep("por");
        rd(2'b11, 10'd5); sample();
        chk("por_rd_dout", dout, 64'd0);
        chk("por_rd_vld", {62'd0, vld}, 64'd3);

        // Independent bank writes, dual read
        wr(2'b01, 10'd5, 64'h0000_0000_A5A5_0001);
        wr(2'b10, 10'd5, 64'h0000_FFFF_0000_0000);
        rd(2'b11, 10'd5); sample();
        chk("dual_dout", dout, 64'h0000_FFFF_A5A5_0001);
        chk("dual_vld", {62'd0, vld}, 64'd3);
        chk("dual_perr", {62'd0, perr}, 64'd0);

        // Write then read next cycle; bank1 holds its last read value
        wr(2'b01, 10'd7, 64'h0000_0000_1234_5678);
        rd(2'b01, 10'd7); sample();
        chk("b2b_dout", dout, 64'h0000_FFFF_1234_5678);
        chk("b2b_vld", {62'd0, vld}, 64'd1);

        // Corrupt one stored bit in bank1 idx 9 of both builds
        wr(2'b11, 10'd9, 64'hDEAD_BEEF_0F0F_0F0F);
        idle(1);
        @(negedge clk);
        dut.g_bank[1].u_bank.r_mem[9][3]    = ~dut.g_bank[1].u_bank.r_mem[9][3];
        dut_np.g_bank[1].u_bank.r_mem[9][3] = ~dut_np.g_bank[1].u_bank.r_mem[9][3];
        m_mem[1][9][3] = ~m_mem[1][9][3];
        rd(2'b10, 10'd9); sample();
        chk("flip_dout", dout, 64'hDEAD_BEE7_1234_5678);
        chk("flip_vld", {62'd0, vld}, 64'd2);
        chk("flip_perr", {62'd0, perr}, 64'd2);
        chk("flip_np_perr", {62'd0, perr_np}, 64'd0);
        rd(2'b01, 10'd9); sample();
        chk("flip_b0_perr", {62'd0, perr}, 64'd0);

        // Requested sweep with accesses and a second request while busy
        for (int i = 0; i < 4; i++) wr(2'b11, 10'(i), {32'hC0DE_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)});
        @(negedge clk);
        cen_b = 2'b00; wen_b = 1'b1; index = 10'd1; inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        fork
            wait_sweep("req");
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    cen_b = 2'b00; wen_b = i[0]; index = 10'(i % 4);
                    din = 64'hFFFF_FFFF_FFFF_FFFF;
                    inv_req = (i == 9);
                end
                @(negedge clk);
                cen_b = '1; wen_b = 1'b1; inv_req = 1'b0;
            end
        join
        for (int i = 0; i < 4; i++) begin
            rd(2'b11, 10'(i)); sample();
            chk("swept_dout", dout, 64'd0);
            chk("swept_vld", {62'd0, vld}, 64'd3);
        end

        // Reset in the middle of a sweep restarts it from index 0
        @(negedge clk); inv_req = 1'b1;
        @(negedge clk); inv_req = 1'b0;
        early_done = 0;
        repeat (499) begin
            @(posedge clk); #2;
            if (done) early_done++;
        end
        chk("mid_no_done", 64'(early_done), 64'd0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd1);
        wait_sweep("mid");
        rd(2'b11, 10'd9); sample();
        chk("post_dout", dout, 64'd0);
        chk("post_perr", {62'd0, perr}, 64'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
